// File: rtl/pkt_buffer.sv
// pkt_buffer
//    Ingress packet store in front of the header parser. Two ping-pong slots
//    each hold one complete packet of up to BUF_BYTES bytes. The parser reads
//    any 4-byte big-endian window of the presented packet with a one-cycle
//    latency and releases the packet with pkt_done.
//
// Ports
//    clk        clock
//    rst        synchronous reset, active low
//    in_data    ingress byte
//    in_valid   in_data is valid
//    in_last    final byte of the packet
//    in_ready   buffer can accept a byte this cycle
//    pkt_valid  a complete packet is presented in the read slot
//    pkt_len    byte length of the presented packet (0 when none)
//    pkt_done   parser releases the presented packet
//    tag_addr   byte offset of the tag window
//    tag_data   bytes tag_addr..tag_addr+3, byte tag_addr in the MSBs
//    drop_cnt   saturating count of discarded oversize packets
module pkt_buffer #(
   parameter int BUF_BYTES  = 256,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   input  logic                  in_last,
   output logic                  in_ready,
   output logic                  pkt_valid,
   output logic [ADDR_WIDTH:0]   pkt_len,
   input  logic                  pkt_done,
   input  logic [ADDR_WIDTH-1:0] tag_addr,
   output logic [DATA_WIDTH-1:0] tag_data,
   output logic [15:0]           drop_cnt
);

   typedef enum logic [1:0] {
      S_EMPTY   = 2'd0,
      S_FILLING = 2'd1,
      S_FULL    = 2'd2
   } slot_state_t;

   localparam logic [ADDR_WIDTH:0] CAP = (ADDR_WIDTH+1)'(BUF_BYTES);

   slot_state_t           state_q [2];
   slot_state_t           state_d [2];
   logic [ADDR_WIDTH:0]   len_q   [2];
   logic [ADDR_WIDTH:0]   len_d   [2];
   logic                  wr_sel_q, wr_sel_d;
   logic                  rd_sel_q, rd_sel_d;
   logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
   logic                  ovf_q, ovf_d;
   logic [15:0]           drop_q, drop_d;

   logic [7:0]            mem [2][BUF_BYTES];

   logic                  accept;
   logic                  store_en;
   logic                  ovf_now;
   logic [DATA_WIDTH-1:0] rd_word;

   // ---------------------------------------------------------------------
   // Status outputs
   // ---------------------------------------------------------------------
   assign in_ready  = rst && (state_q[wr_sel_q] != S_FULL);
   assign accept    = in_valid && in_ready;
   assign pkt_valid = (state_q[rd_sel_q] == S_FULL);
   assign pkt_len   = pkt_valid ? len_q[rd_sel_q] : '0;
   assign drop_cnt  = drop_q;

   // ---------------------------------------------------------------------
   // Slot state registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q[0] <= S_EMPTY;
         state_q[1] <= S_EMPTY;
         len_q[0]   <= '0;
         len_q[1]   <= '0;
         wr_sel_q   <= 1'b0;
         rd_sel_q   <= 1'b0;
         wr_ptr_q   <= '0;
         ovf_q      <= 1'b0;
         drop_q     <= '0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         wr_sel_q   <= wr_sel_d;
         rd_sel_q   <= rd_sel_d;
         wr_ptr_q   <= wr_ptr_d;
         ovf_q      <= ovf_d;
         drop_q     <= drop_d;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic. Only one slot fills at a time, so a single write
   // pointer and overflow flag serve both slots. The write and read sides
   // never touch the same slot in one cycle: if the read slot is FULL and
   // is also the write slot, in_ready is low.
   // ---------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      wr_sel_d = wr_sel_q;
      rd_sel_d = rd_sel_q;
      wr_ptr_d = wr_ptr_q;
      ovf_d    = ovf_q;
      drop_d   = drop_q;
      store_en = 1'b0;
      ovf_now  = ovf_q;

      if (accept) begin
         if (state_q[wr_sel_q] == S_EMPTY) begin
            state_d[wr_sel_q] = S_FILLING;
         end

         if (wr_ptr_q < CAP) begin
            store_en = 1'b1;
         end else begin
            ovf_now = 1'b1;
         end

         wr_ptr_d = (wr_ptr_q == CAP) ? wr_ptr_q : wr_ptr_q + 1'b1;
         ovf_d    = ovf_now;

         if (in_last) begin
            if (!ovf_now) begin
               state_d[wr_sel_q] = S_FULL;
               len_d[wr_sel_q]   = wr_ptr_q + 1'b1;
               wr_sel_d          = ~wr_sel_q;
            end else begin
               // Oversize: discard and reuse the same slot.
               state_d[wr_sel_q] = S_EMPTY;
               if (drop_q != '1) begin
                  drop_d = drop_q + 1'b1;
               end
            end
            wr_ptr_d = '0;
            ovf_d    = 1'b0;
         end
      end

      if (pkt_done && pkt_valid) begin
         state_d[rd_sel_q] = S_EMPTY;
         rd_sel_d          = ~rd_sel_q;
      end
   end

   // ---------------------------------------------------------------------
   // Packet storage
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (store_en) begin
         mem[wr_sel_q][wr_ptr_q[ADDR_WIDTH-1:0]] <= in_data;
      end
   end

   // ---------------------------------------------------------------------
   // Tag read: each byte index is formed two bits wider than the offset so
   // windows running past the packet end are zeroed instead of wrapping.
   // ---------------------------------------------------------------------
   always_comb begin
      logic [ADDR_WIDTH+1:0] idx;
      rd_word = '0;
      idx     = '0;
      for (int unsigned k = 0; k < DATA_WIDTH / 8; k++) begin
         idx = {2'b00, tag_addr} + (ADDR_WIDTH+2)'(k);
         if (idx < {1'b0, pkt_len}) begin
            rd_word[DATA_WIDTH-1-8*k -: 8] = mem[rd_sel_q][idx[ADDR_WIDTH-1:0]];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         tag_data <= '0;
      end else begin
         tag_data <= pkt_valid ? rd_word : '0;
      end
   end

endmodule

// File: tb/tb_pkt_buffer.sv
// tb_pkt_buffer
//    Self-checking bench for pkt_buffer. A packet-FIFO reference model
//    (at most two stored packets, front one presented) predicts every
//    output after each clock edge; directed sequences and a tag-read table
//    add fixed expected values for the documented scenarios.
module tb_pkt_buffer;

   logic        clk;
   logic        rst;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_last;
   logic        in_ready;
   logic        pkt_valid;
   logic [8:0]  pkt_len;
   logic        pkt_done;
   logic [7:0]  tag_addr;
   logic [31:0] tag_data;
   logic [15:0] drop_cnt;

   pkt_buffer #(
      .BUF_BYTES (256),
      .ADDR_WIDTH(8),
      .DATA_WIDTH(32)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_last  (in_last),
      .in_ready (in_ready),
      .pkt_valid(pkt_valid),
      .pkt_len  (pkt_len),
      .pkt_done (pkt_done),
      .tag_addr (tag_addr),
      .tag_data (tag_data),
      .drop_cnt (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: FIFO of complete packets plus the packet in progress.
   logic [7:0]  mq [2][256];
   int          mlen [2];
   int          mcnt;
   logic [7:0]  pbuf [256];
   int          pcnt;
   bit          povf;
   int          mdrop;
   logic [31:0] exp_tag;
   bit          last_acc;
   bit          done_on_last;
   logic [7:0]  pat [512];

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] exp;
   } vec_t;
   vec_t tbl [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   task automatic model_edge();
      logic [31:0] t;
      int idx;
      last_acc = 1'b0;
      if (!rst) begin
         mcnt = 0; pcnt = 0; povf = 1'b0; mdrop = 0; exp_tag = '0;
         return;
      end
      t = '0;
      if (mcnt > 0) begin
         for (int k = 0; k < 4; k++) begin
            idx = int'(tag_addr) + k;
            if (idx < mlen[0]) t[31-8*k -: 8] = mq[0][idx];
         end
      end
      exp_tag  = t;
      last_acc = in_valid && (mcnt < 2);
      if (pkt_done && mcnt > 0) begin
         for (int j = 0; j < 256; j++) mq[0][j] = mq[1][j];
         mlen[0] = mlen[1];
         mcnt--;
      end
      if (last_acc) begin
         if (pcnt < 256) begin
            pbuf[pcnt] = in_data;
            pcnt++;
         end else begin
            povf = 1'b1;
         end
         if (in_last) begin
            if (!povf) begin
               for (int j = 0; j < 256; j++) mq[mcnt][j] = pbuf[j];
               mlen[mcnt] = pcnt;
               mcnt++;
            end else if (mdrop < 65535) begin
               mdrop++;
            end
            pcnt = 0;
            povf = 1'b0;
         end
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      chk("in_ready",  {31'b0, in_ready},  {31'b0, (rst && mcnt < 2)});
      chk("pkt_valid", {31'b0, pkt_valid}, {31'b0, (mcnt > 0)});
      chk("pkt_len",   {23'b0, pkt_len},   (mcnt > 0) ? mlen[0] : 0);
      chk("tag_data",  tag_data,           exp_tag);
      chk("drop_cnt",  {16'b0, drop_cnt},  mdrop);
   endtask

   task automatic fill(input logic [7:0] base);
      for (int i = 0; i < 512; i++) pat[i] = base + 8'(i);
   endtask

   task automatic send(input int n, input bit with_last);
      int i = 0;
      int guard = 0;
      while (i < n) begin
         in_valid = 1'b1;
         in_data  = pat[i];
         in_last  = with_last && (i == n - 1);
         pkt_done = done_on_last && in_last;
         tick();
         if (last_acc) begin
            i++;
            guard = 0;
         end else if (++guard > 200) begin
            n_total++;
            $display("FAIL send_timeout: byte %0d of %0d not accepted", i, n);
            break;
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      pkt_done = 1'b0;
   endtask

   task automatic release_pkt();
      pkt_done = 1'b1;
      tick();
      pkt_done = 1'b0;
   endtask

   function automatic int new_len();
      return ($urandom % 8 == 0) ? 250 + int'($urandom % 12) : 1 + int'($urandom % 40);
   endfunction

   initial begin
      int rem;

      tbl[0] = '{8'd12,  32'h0800_4500};
      tbl[1] = '{8'd0,   32'h0001_0203};
      tbl[2] = '{8'd10,  32'h0A0B_0800};
      tbl[3] = '{8'd14,  32'h4500_1011};
      tbl[4] = '{8'd57,  32'h393A_3B00};
      tbl[5] = '{8'd59,  32'h3B00_0000};
      tbl[6] = '{8'd60,  32'h0000_0000};
      tbl[7] = '{8'd255, 32'h0000_0000};

      rst = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0;
      pkt_done = 1'b0; tag_addr = '0; done_on_last = 1'b0;
      mcnt = 0; pcnt = 0; povf = 1'b0; mdrop = 0; exp_tag = '0;
      mlen[0] = 0; mlen[1] = 0;

      // Reset state
      tick();
      tick();
      chk("rst_in_ready",  {31'b0, in_ready},  0);
      chk("rst_pkt_valid", {31'b0, pkt_valid}, 0);
      chk("rst_pkt_len",   {23'b0, pkt_len},   0);
      chk("rst_tag_data",  tag_data,           0);
      chk("rst_drop_cnt",  {16'b0, drop_cnt},  0);
      rst = 1'b1;

      // Ethernet/IPv4 header reads from a 60-byte packet
      for (int i = 0; i < 512; i++) pat[i] = 8'(i);
      pat[12] = 8'h08; pat[13] = 8'h00; pat[14] = 8'h45; pat[15] = 8'h00;
      send(60, 1'b1);
      chk("eth_valid", {31'b0, pkt_valid}, 1);
      chk("eth_len",   {23'b0, pkt_len},   60);
      for (int i = 0; i < 8; i++) begin
         tag_addr = tbl[i].addr;
         tick();
         chk("eth_tag",     tag_data,         tbl[i].exp);
         chk("eth_tag_len", {23'b0, pkt_len}, 60);
      end
      release_pkt();
      chk("eth_released", {31'b0, pkt_valid}, 0);

      // Tail read on a 14-byte packet
      fill(8'h80);
      send(14, 1'b1);
      tag_addr = 8'd12;
      tick();
      chk("tail_12", tag_data, 32'h8C8D_0000);
      tag_addr = 8'd13;
      tick();
      chk("tail_13", tag_data, 32'h8D00_0000);
      release_pkt();

      // Back-pressure with three 20-byte packets
      tag_addr = 8'd0;
      fill(8'h10);
      send(20, 1'b1);
      fill(8'h40);
      send(20, 1'b1);
      chk("bp_ready_low", {31'b0, in_ready}, 0);
      fill(8'h70);
      in_valid = 1'b1;
      in_data  = pat[0];
      tick();
      tick();
      pkt_done = 1'b1;
      tick();
      pkt_done = 1'b0;
      chk("bp_ready_back", {31'b0, in_ready},  1);
      chk("bp_valid_held", {31'b0, pkt_valid}, 1);
      chk("bp_len_b",      {23'b0, pkt_len},   20);
      send(20, 1'b1);
      chk("bp_tag_b", tag_data, 32'h4041_4243);
      release_pkt();
      chk("bp_valid_c", {31'b0, pkt_valid}, 1);
      tick();
      chk("bp_tag_c", tag_data, 32'h7071_7273);
      release_pkt();
      chk("bp_drained", {31'b0, pkt_valid}, 0);

      // Oversize packet followed by a normal one
      fill(8'h00);
      send(300, 1'b1);
      chk("ovs_drop",  {16'b0, drop_cnt},  1);
      chk("ovs_valid", {31'b0, pkt_valid}, 0);
      fill(8'h20);
      send(64, 1'b1);
      chk("ovs_next_valid", {31'b0, pkt_valid}, 1);
      chk("ovs_next_len",   {23'b0, pkt_len},   64);
      tick();
      chk("ovs_next_tag", tag_data, 32'h2021_2223);

      // in_last of B on the same edge as pkt_done of A
      fill(8'hC0);
      done_on_last = 1'b1;
      send(10, 1'b1);
      done_on_last = 1'b0;
      chk("sim_valid", {31'b0, pkt_valid}, 1);
      chk("sim_len",   {23'b0, pkt_len},   10);
      tick();
      chk("sim_tag", tag_data, 32'hC0C1_C2C3);
      release_pkt();

      // Reset with one packet held and 30 bytes of another in flight
      fill(8'h33);
      send(12, 1'b1);
      fill(8'h90);
      send(30, 1'b0);
      rst = 1'b0;
      tick();
      chk("mrst_valid", {31'b0, pkt_valid}, 0);
      chk("mrst_tag",   tag_data,           0);
      chk("mrst_drop",  {16'b0, drop_cnt},  0);
      rst = 1'b1;
      #1;
      chk("mrst_ready", {31'b0, in_ready}, 1);
      pat[0] = 8'h5A;
      send(1, 1'b1);
      chk("mrst_len1", {23'b0, pkt_len}, 1);
      tick();
      chk("mrst_tag1", tag_data, 32'h5A00_0000);
      release_pkt();

      // Randomized traffic against the model
      rem = new_len();
      for (int c = 0; c < 4000; c++) begin
         rst      = ($urandom % 700 == 0) ? 1'b0 : 1'b1;
         in_valid = ($urandom % 10 < 7);
         in_data  = 8'($urandom);
         in_last  = (rem == 1);
         pkt_done = ($urandom % 6 == 0);
         tag_addr = ($urandom % 4 == 0) ? 8'($urandom) : 8'($urandom % 48);
         tick();
         if (!rst) rem = new_len();
         else if (last_acc) begin
            rem--;
            if (rem == 0) rem = new_len();
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
